// File: rtl/dm_sba_ctrl_pkg.sv
// ============================================================================
// dm_sba_ctrl_pkg : shared types, codes and lane helpers for the SBA controller
// Revision: 1.0
// ============================================================================
`default_nettype none

package dm_sba_ctrl_pkg;

  typedef enum logic [2:0] {
    SbaIdle      = 3'd0,
    SbaRead      = 3'd1,
    SbaWrite     = 3'd2,
    SbaWaitRead  = 3'd3,
    SbaWaitWrite = 3'd4
  } sba_state_e;

  localparam logic [2:0] SbErrNone  = 3'd0;
  localparam logic [2:0] SbErrBus   = 3'd2;
  localparam logic [2:0] SbErrAlign = 3'd3;
  localparam logic [2:0] SbErrSize  = 3'd4;

  localparam logic [2:0] SbAccess8  = 3'd0;
  localparam logic [2:0] SbAccess16 = 3'd1;
  localparam logic [2:0] SbAccess32 = 3'd2;

  function automatic logic sba_misaligned(input logic [1:0] a, input logic [2:0] acc);
    return ((acc == SbAccess16) && a[0]) || ((acc == SbAccess32) && (a != 2'b00));
  endfunction

  function automatic logic [31:0] sba_wdata(input logic [31:0] d, input logic [2:0] acc);
    case (acc)
      SbAccess8:  return {4{d[7:0]}};
      SbAccess16: return {2{d[15:0]}};
      default:    return d;
    endcase
  endfunction

  function automatic logic [3:0] sba_be(input logic [1:0] a, input logic [2:0] acc);
    case (acc)
      SbAccess8:  return 4'b0001 << a;
      SbAccess16: return 4'b0011 << a;
      default:    return 4'hF;
    endcase
  endfunction

  // Bring the addressed lane down to bit 0 and clear everything above the access size.
  function automatic logic [31:0] sba_rdata(input logic [31:0] rd, input logic [1:0] a,
                                            input logic [2:0] acc);
    logic [31:0] sh;
    sh = rd >> {a, 3'b000};
    case (acc)
      SbAccess8:  return {24'h0, sh[7:0]};
      SbAccess16: return {16'h0, sh[15:0]};
      default:    return sh;
    endcase
  endfunction

  function automatic logic [31:0] sba_incr(input logic [2:0] acc);
    return 32'd1 << acc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dm_sba_ctrl_if.sv
// ============================================================================
// dm_sba_ctrl_if : single-beat system bus master port used by the SBA block
// Revision: 1.0
// ============================================================================
`default_nettype none

interface dm_sba_ctrl_if;
  logic        req_o;
  logic [31:0] add_o;
  logic        we_o;
  logic [31:0] wdata_o;
  logic [3:0]  be_o;
  logic        gnt_i;
  logic        rvalid_i;
  logic [31:0] rdata_i;
  logic        err_i;

  modport master (
    output req_o, add_o, we_o, wdata_o, be_o,
    input  gnt_i, rvalid_i, rdata_i, err_i
  );

  modport slave (
    input  req_o, add_o, we_o, wdata_o, be_o,
    output gnt_i, rvalid_i, rdata_i, err_i
  );
endinterface

`default_nettype wire

// File: rtl/dm_sba_ctrl.sv
// ============================================================================
// dm_sba_ctrl : debug-module System Bus Access controller (single 32-bit beats)
// Revision: 1.0
// ============================================================================
`default_nettype none

module dm_sba_ctrl
  import dm_sba_ctrl_pkg::*;
#(
  parameter int BUS_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,

  input  logic [BUS_WIDTH-1:0] sbaddress_i,
  input  logic                 sbaddress_write_valid_i,
  input  logic [BUS_WIDTH-1:0] sbdata_i,
  input  logic                 sbdata_write_valid_i,
  input  logic                 sbdata_read_valid_i,
  input  logic                 sbreadonaddr_i,
  input  logic                 sbreadondata_i,
  input  logic                 sbautoincrement_i,
  input  logic [2:0]           sbaccess_i,

  output logic [BUS_WIDTH-1:0] sbaddress_o,
  output logic [BUS_WIDTH-1:0] sbdata_o,
  output logic                 sbdata_valid_o,
  output logic                 sbbusy_o,
  output logic                 sbbusyerror_o,
  output logic                 sberror_valid_o,
  output logic [2:0]           sberror_o,

  dm_sba_ctrl_if.master        bus
);

  sba_state_e          r_state;
  sba_state_e          w_state_next;

  logic [BUS_WIDTH-1:0] r_addr;
  logic [BUS_WIDTH-1:0] r_txn_addr;
  logic [BUS_WIDTH-1:0] r_wdata;
  logic [BUS_WIDTH-1:0] r_data;
  logic [2:0]           r_access;
  logic                 r_autoinc;
  logic                 r_data_valid;
  logic                 r_busyerr;
  logic                 r_err_valid;
  logic [2:0]           r_err;

  logic                 w_idle;
  logic                 w_trig_write;
  logic                 w_trig_read;
  logic                 w_trig;
  logic [BUS_WIDTH-1:0] w_eff_addr;
  logic                 w_size_err;
  logic                 w_align_err;
  logic                 w_launch;
  logic                 w_busy_err;
  logic                 w_done;

  assign w_idle       = (r_state == SbaIdle);
  assign w_trig_write = sbdata_write_valid_i;
  assign w_trig_read  = (sbaddress_write_valid_i && sbreadonaddr_i) ||
                        (sbdata_read_valid_i && sbreadondata_i);
  assign w_trig       = w_trig_write || w_trig_read;
  // A read-on-address trigger must use the address arriving in the same cycle.
  assign w_eff_addr   = sbaddress_write_valid_i ? sbaddress_i : r_addr;
  assign w_size_err   = (sbaccess_i > SbAccess32);
  assign w_align_err  = sba_misaligned(w_eff_addr[1:0], sbaccess_i);
  assign w_launch     = w_idle && w_trig && !w_size_err && !w_align_err;
  assign w_busy_err   = !w_idle && (w_trig || sbaddress_write_valid_i);
  assign w_done       = bus.rvalid_i &&
                        ((r_state == SbaWaitRead) || (r_state == SbaWaitWrite));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= SbaIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SbaIdle:      if (w_launch) w_state_next = w_trig_write ? SbaWrite : SbaRead;
      SbaRead:      if (bus.gnt_i) w_state_next = SbaWaitRead;
      SbaWrite:     if (bus.gnt_i) w_state_next = SbaWaitWrite;
      SbaWaitRead,
      SbaWaitWrite: if (bus.rvalid_i) w_state_next = SbaIdle;
      default:      w_state_next = SbaIdle;
    endcase
  end

  always_comb begin
    bus.req_o   = 1'b0;
    bus.add_o   = '0;
    bus.we_o    = 1'b0;
    bus.wdata_o = '0;
    bus.be_o    = '0;
    case (r_state)
      SbaRead, SbaWrite: begin
        bus.req_o = 1'b1;
        bus.add_o = {r_txn_addr[31:2], 2'b00};
        bus.be_o  = sba_be(r_txn_addr[1:0], r_access);
        if (r_state == SbaWrite) begin
          bus.we_o    = 1'b1;
          bus.wdata_o = sba_wdata(r_wdata, r_access);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addr       <= '0;
      r_txn_addr   <= '0;
      r_wdata      <= '0;
      r_data       <= '0;
      r_access     <= SbAccess32;
      r_autoinc    <= 1'b0;
      r_data_valid <= 1'b0;
      r_busyerr    <= 1'b0;
      r_err_valid  <= 1'b0;
      r_err        <= SbErrNone;
    end else begin
      r_data_valid <= 1'b0;
      r_err_valid  <= 1'b0;
      r_busyerr    <= w_busy_err;

      if (sbaddress_write_valid_i) begin
        r_addr <= sbaddress_i;
      end

      if (w_idle && w_trig) begin
        if (w_size_err) begin
          r_err_valid <= 1'b1;
          r_err       <= SbErrSize;
        end else if (w_align_err) begin
          r_err_valid <= 1'b1;
          r_err       <= SbErrAlign;
        end else begin
          r_txn_addr <= w_eff_addr;
          r_access   <= sbaccess_i;
          r_autoinc  <= sbautoincrement_i;
          if (w_trig_write) begin
            r_wdata <= sbdata_i;
          end
        end
      end

      // Completion overrides a same-cycle address load: the increment follows the access.
      if (w_done) begin
        if (bus.err_i) begin
          r_err_valid <= 1'b1;
          r_err       <= SbErrBus;
        end else begin
          if (r_state == SbaWaitRead) begin
            r_data       <= sba_rdata(bus.rdata_i, r_txn_addr[1:0], r_access);
            r_data_valid <= 1'b1;
          end
          if (r_autoinc) begin
            r_addr <= r_txn_addr + sba_incr(r_access);
          end
        end
      end
    end
  end

  assign sbaddress_o     = r_addr;
  assign sbdata_o        = r_data;
  assign sbdata_valid_o  = r_data_valid;
  assign sbbusy_o        = !w_idle;
  assign sbbusyerror_o   = r_busyerr;
  assign sberror_valid_o = r_err_valid;
  assign sberror_o       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_dm_sba_ctrl.sv
// ============================================================================
// tb_dm_sba_ctrl : scoreboard bench for dm_sba_ctrl with a scripted bus slave
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dm_sba_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] sbaddress_i = '0;
  logic        sbaddress_write_valid_i = 1'b0;
  logic [31:0] sbdata_i = '0;
  logic        sbdata_write_valid_i = 1'b0;
  logic        sbdata_read_valid_i = 1'b0;
  logic        sbreadonaddr_i = 1'b0;
  logic        sbreadondata_i = 1'b0;
  logic        sbautoincrement_i = 1'b0;
  logic [2:0]  sbaccess_i = 3'd2;
  logic [31:0] sbaddress_o;
  logic [31:0] sbdata_o;
  logic        sbdata_valid_o;
  logic        sbbusy_o;
  logic        sbbusyerror_o;
  logic        sberror_valid_o;
  logic [2:0]  sberror_o;

  dm_sba_ctrl_if bus ();

  dm_sba_ctrl dut (
    .clk_i                   (clk),
    .rst_i                   (rst),
    .sbaddress_i             (sbaddress_i),
    .sbaddress_write_valid_i (sbaddress_write_valid_i),
    .sbdata_i                (sbdata_i),
    .sbdata_write_valid_i    (sbdata_write_valid_i),
    .sbdata_read_valid_i     (sbdata_read_valid_i),
    .sbreadonaddr_i          (sbreadonaddr_i),
    .sbreadondata_i          (sbreadondata_i),
    .sbautoincrement_i       (sbautoincrement_i),
    .sbaccess_i              (sbaccess_i),
    .sbaddress_o             (sbaddress_o),
    .sbdata_o                (sbdata_o),
    .sbdata_valid_o          (sbdata_valid_o),
    .sbbusy_o                (sbbusy_o),
    .sbbusyerror_o           (sbbusyerror_o),
    .sberror_valid_o         (sberror_valid_o),
    .sberror_o               (sberror_o),
    .bus                     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] add;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  typedef struct {
    int          gnt_dly;
    int          rsp_dly;
    logic [31:0] rdata;
    logic        err;
    logic        dual;
    logic        abort;
  } plan_t;

  req_t        q_req[$];
  plan_t       q_plan[$];
  logic [31:0] q_rd[$];
  logic [2:0]  q_err[$];
  int          q_busy[$];

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_data = '0;
  bit          in_wait = 1'b0;
  bit          late_go = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got event expected none", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every DUT output event is matched against the front of its queue.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.req_o) begin
        if (q_req.size() == 0) fail_now("unexpected_req");
        else begin
          check("req_add_we_be", {bus.add_o, bus.we_o, bus.be_o},
                {q_req[0].add, q_req[0].we, q_req[0].be});
          if (q_req[0].we) check("req_wdata", bus.wdata_o, q_req[0].wdata);
          if (bus.gnt_i) void'(q_req.pop_front());
        end
      end
      if (sbdata_valid_o) begin
        if (q_rd.size() == 0) fail_now("unexpected_sbdata_valid");
        else check("sbdata_o", sbdata_o, q_rd.pop_front());
      end
      if (sberror_valid_o) begin
        if (q_err.size() == 0) fail_now("unexpected_sberror");
        else check("sberror_o", sberror_o, q_err.pop_front());
      end
      if (sbbusyerror_o) begin
        if (q_busy.size() == 0) fail_now("unexpected_sbbusyerror");
        else void'(q_busy.pop_front());
      end
    end
  end

  // Bus slave: follows one plan entry per observed request.
  initial begin
    plan_t p;
    bus.gnt_i = 1'b0; bus.rvalid_i = 1'b0; bus.rdata_i = '0; bus.err_i = 1'b0;
    forever begin
      step();
      if (bus.req_o) begin
        if (q_plan.size() == 0) begin
          fail_now("req_without_plan");
          p = '{gnt_dly: 0, rsp_dly: 0, rdata: 32'h0, err: 1'b0, dual: 1'b0, abort: 1'b0};
        end else p = q_plan.pop_front();
        repeat (p.gnt_dly) step();
        bus.gnt_i = 1'b1;
        if (p.dual) begin
          bus.rvalid_i = 1'b1; bus.rdata_i = ~p.rdata; bus.err_i = $urandom_range(0, 1) == 1;
        end
        step();
        bus.gnt_i = 1'b0; bus.rvalid_i = 1'b0; bus.err_i = 1'b0;
        if (p.abort) begin
          in_wait = 1'b1;
          for (int i = 0; i < 100 && !late_go; i++) step();
        end else repeat (p.rsp_dly) step();
        bus.rvalid_i = 1'b1; bus.rdata_i = p.rdata; bus.err_i = p.err;
        step();
        bus.rvalid_i = 1'b0; bus.err_i = 1'b0;
      end
    end
  end

  task automatic set_addr(input logic [31:0] a);
    sbaddress_i = a; sbaddress_write_valid_i = 1'b1; sbreadonaddr_i = 1'b0;
    step();
    sbaddress_write_valid_i = 1'b0;
    m_addr = a;
  endtask

  // kind 0: write via sbdata write, 1: read on address write, 2: read on sbdata read
  task automatic txn(input int kind, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] acc, input bit ainc, input plan_t p, input bit inject);
    logic [31:0] ea;
    logic [63:0] mask;
    req_t        r;
    int          sz;
    int          bt;
    bit          launched;
    launched = 1'b0;
    sbaccess_i = acc; sbautoincrement_i = ainc;
    case (kind)
      0:       begin sbdata_i = d; sbdata_write_valid_i = 1'b1; end
      1:       begin sbaddress_i = a; sbaddress_write_valid_i = 1'b1; sbreadonaddr_i = 1'b1; end
      default: begin sbdata_read_valid_i = 1'b1; sbreadondata_i = 1'b1; end
    endcase
    if (kind == 1) m_addr = a;
    ea = m_addr;
    if (acc > 3'd2) q_err.push_back(3'd4);
    else begin
      sz = 1 << acc;
      if ((ea % sz) != 0) q_err.push_back(3'd3);
      else begin
        launched = 1'b1;
        bt = ((1 << sz) - 1) << (ea % 4);
        r.add = ea & 32'hFFFF_FFFC;
        r.we = (kind == 0);
        r.be = bt[3:0];
        r.wdata = (sz == 1) ? (d & 32'hFF) * 32'h0101_0101 :
                  (sz == 2) ? (d & 32'hFFFF) * 32'h0001_0001 : d;
        q_req.push_back(r);
        q_plan.push_back(p);
        if (p.err) q_err.push_back(3'd2);
        else begin
          if (kind != 0) begin
            mask = (64'd1 << (8 * sz)) - 64'd1;
            m_data = (p.rdata >> (8 * (ea % 4))) & mask[31:0];
            q_rd.push_back(m_data);
          end
          if (ainc) m_addr = ea + sz;
        end
      end
    end
    step();
    sbdata_write_valid_i = 1'b0; sbaddress_write_valid_i = 1'b0; sbdata_read_valid_i = 1'b0;
    sbreadonaddr_i = 1'b0; sbreadondata_i = 1'b0;
    // Control fields change mid-transaction; the DUT must use the values sampled at trigger.
    sbaccess_i = 3'($urandom_range(0, 7)); sbautoincrement_i = $urandom_range(0, 1) == 1;
    if (inject && launched) begin
      sbdata_i = $urandom; sbdata_write_valid_i = 1'b1;
      q_busy.push_back(1);
      step();
      sbdata_write_valid_i = 1'b0;
    end
    for (int i = 0; i < 60 && sbbusy_o; i++) step();
    if (sbbusy_o) fail_now("busy_timeout");
    step(); step();
    check("sbaddress_o", sbaddress_o, m_addr);
    check("sbdata_hold", sbdata_o, m_data);
  endtask

  function automatic plan_t mk_plan(input int g, input int r, input logic [31:0] rd,
                                    input logic e, input logic du);
    plan_t p;
    p = '{gnt_dly: g, rsp_dly: r, rdata: rd, err: e, dual: du, abort: 1'b0};
    return p;
  endfunction

  initial begin
    plan_t p;
    logic [31:0] a;
    logic [2:0]  acc;
    int          kind;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", sbbusy_o, 1'b0);
    rst = 1'b0;
    step();
    check("rst_outputs", {sbaddress_o, sbdata_o, sbdata_valid_o, sbbusyerror_o, sberror_valid_o},
          {32'h0, 32'h0, 1'b0, 1'b0, 1'b0});
    check("rst_bus", {bus.req_o, bus.add_o, bus.we_o, bus.wdata_o, bus.be_o}, 70'h0);

    set_addr(32'h1000);
    txn(0, 32'h0, 32'hDEAD_BEEF, 3'd2, 1'b1, mk_plan(0, 0, 32'h0, 1'b0, 1'b0), 1'b0);
    txn(1, 32'h1003, 32'h0, 3'd0, 1'b0, mk_plan(1, 2, 32'hAABB_CCDD, 1'b0, 1'b0), 1'b0);
    txn(1, 32'h1001, 32'h0, 3'd1, 1'b0, mk_plan(0, 0, 32'h0, 1'b0, 1'b0), 1'b0);
    txn(2, 32'h0, 32'h0, 3'd3, 1'b0, mk_plan(0, 0, 32'h0, 1'b0, 1'b0), 1'b0);
    txn(1, 32'h2000, 32'h0, 3'd2, 1'b0, mk_plan(5, 1, 32'h1111_2222, 1'b0, 1'b0), 1'b1);
    txn(2, 32'h0, 32'h0, 3'd2, 1'b1, mk_plan(0, 1, 32'h5555_6666, 1'b1, 1'b0), 1'b0);
    txn(2, 32'h0, 32'h0, 3'd1, 1'b1, mk_plan(0, 0, 32'h7788_99AA, 1'b0, 1'b1), 1'b0);
    set_addr(32'hFFFF_FFFC);
    txn(0, 32'h0, 32'h0102_0304, 3'd2, 1'b1, mk_plan(2, 0, 32'h0, 1'b0, 1'b0), 1'b0);

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 2);
      acc  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      a    = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (acc == 3'd1) a[0] = 1'b0;
        if (acc == 3'd2) a[1:0] = 2'b00;
      end
      if (kind != 1 && $urandom_range(0, 2) != 0) set_addr(a);
      p = mk_plan($urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0);
      txn(kind, a, $urandom, acc, $urandom_range(0, 1) == 1, p, $urandom_range(0, 5) == 0);
    end

    // Reset while waiting for a read response; the late response must be ignored.
    q_req.push_back('{add: 32'h3000, we: 1'b0, wdata: 32'h0, be: 4'hF});
    q_plan.push_back('{gnt_dly: 0, rsp_dly: 0, rdata: 32'h1234_5678, err: 1'b0,
                       dual: 1'b0, abort: 1'b1});
    sbaccess_i = 3'd2; sbaddress_i = 32'h3000; sbaddress_write_valid_i = 1'b1; sbreadonaddr_i = 1'b1;
    step();
    sbaddress_write_valid_i = 1'b0; sbreadonaddr_i = 1'b0;
    for (int i = 0; i < 50 && !in_wait; i++) step();
    if (!in_wait) fail_now("wait_read_timeout");
    step();
    rst = 1'b1;
    #1;
    check("async_rst_busy", sbbusy_o, 1'b0);
    step();
    rst = 1'b0; late_go = 1'b1;
    m_addr = '0; m_data = '0;
    repeat (6) step();
    check("post_rst_state", {sbbusy_o, sbdata_o, sbaddress_o}, {1'b0, 32'h0, 32'h0});

    check("left_req", q_req.size(), 0);
    check("left_rd", q_rd.size(), 0);
    check("left_err", q_err.size(), 0);
    check("left_busy", q_busy.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
